// File: rtl/hazard_scoreboard_ctrl_if.sv
// Handshake bundle between the ID stage and the hazard scoreboard: the pipeline drives the
// decoded instruction fields and the branch redirect, the hazard unit drives hold/bubble/flush.
interface hazard_scoreboard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              id_branch;
  logic              id_jump;
  logic              ex_br_taken;
  logic              pc_hold;
  logic              ifid_hold;
  logic              idex_bubble;
  logic              flush_ifid;
  logic              flush_idex;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_regwrite, id_memread,
           id_branch, id_jump, ex_br_taken,
    input  pc_hold, ifid_hold, idex_bubble, flush_ifid, flush_idex, stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_regwrite, id_memread,
           id_branch, id_jump, ex_br_taken,
    output pc_hold, ifid_hold, idex_bubble, flush_ifid, flush_idex, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_scoreboard_ctrl.sv
// Per-register countdown scoreboard hazard unit: stalls ID consumers until producers are
// forwardable, inserts bubbles, issues flushes, and counts stall/flush cycles (saturating).
module hazard_scoreboard_ctrl #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned ALU_LAT  = 0,
  parameter int unsigned BR_EXTRA = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  hazard_scoreboard_ctrl_if.slave bus
);
  localparam int unsigned NREGS  = 2 ** REG_AW;
  localparam int unsigned MaxLat = (LOAD_LAT > ALU_LAT) ? LOAD_LAT : ALU_LAT;
  localparam int unsigned SbRaw  = $clog2(MaxLat + BR_EXTRA + 1);
  localparam int unsigned SbW    = (SbRaw > 0) ? SbRaw : 1;

  typedef logic [SbW-1:0] sb_t;

  localparam sb_t LoadInit = sb_t'(LOAD_LAT + BR_EXTRA);
  localparam sb_t AluInit  = sb_t'(ALU_LAT + BR_EXTRA);
  localparam sb_t BrExtra  = sb_t'(BR_EXTRA);

  sb_t              cnt_q [NREGS];
  sb_t              cnt_d [NREGS];
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             hazard;
  logic             issue;

  // ID-stage branches compare operands early, so they wait the extra BR_EXTRA cycles.
  function automatic logic busy(input sb_t c, input logic br);
    return br ? (c != '0) : (c > BrExtra);
  endfunction

  always_comb begin
    hazard = bus.id_valid &
             ((bus.id_use_rs & busy(cnt_q[bus.id_rs], bus.id_branch)) |
              (bus.id_use_rt & busy(cnt_q[bus.id_rt], bus.id_branch)));
    issue  = bus.id_valid & ~hazard & ~bus.ex_br_taken;
  end

  always_comb begin
    bus.pc_hold     = rst_n & hazard & ~bus.ex_br_taken;
    bus.ifid_hold   = rst_n & hazard & ~bus.ex_br_taken;
    bus.idex_bubble = rst_n & (hazard | bus.ex_br_taken);
    bus.flush_idex  = rst_n & bus.ex_br_taken;
    bus.flush_ifid  = rst_n & (bus.ex_br_taken | (bus.id_valid & bus.id_jump & ~hazard));
    bus.stall_count = stall_q;
    bus.flush_count = flush_q;
  end

  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - sb_t'(1) : '0;
    end
    // A new producer overwrites whatever older write was still pending on the same register.
    if (issue && bus.id_regwrite && (bus.id_rd != '0)) begin
      cnt_d[bus.id_rd] = bus.id_memread ? LoadInit : AluInit;
    end
    cnt_d[0] = '0;
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (bus.pc_hold && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    if (bus.flush_ifid && (flush_q != '1)) flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREGS; r++) cnt_q[r] <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Drives three scoreboard configurations with a shared instruction stream and checks every
// cycle against a timestamp-based reference of when each register result becomes usable.
module tb_hazard_scoreboard_ctrl;
  localparam int NI       = 3;
  localparam int BR_EXTRA = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread, id_branch, id_jump;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       ex_br_taken;

  logic [NI-1:0]       pc_hold, ifid_hold, idex_bubble, flush_ifid, flush_idex;
  logic [NI-1:0][31:0] stall_cnt, flush_cnt;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned LL = (g == 1) ? 3 : 1;
    localparam int unsigned CW = (g == 2) ? 2 : 16;
    hazard_scoreboard_ctrl_if #(.REG_AW(5), .CNT_W(CW)) bus ();
    assign bus.id_valid    = id_valid;
    assign bus.id_rs       = id_rs;
    assign bus.id_rt       = id_rt;
    assign bus.id_use_rs   = id_use_rs;
    assign bus.id_use_rt   = id_use_rt;
    assign bus.id_rd       = id_rd;
    assign bus.id_regwrite = id_regwrite;
    assign bus.id_memread  = id_memread;
    assign bus.id_branch   = id_branch;
    assign bus.id_jump     = id_jump;
    assign bus.ex_br_taken = ex_br_taken;
    hazard_scoreboard_ctrl #(
      .REG_AW(5), .LOAD_LAT(LL), .ALU_LAT(0), .BR_EXTRA(BR_EXTRA), .CNT_W(CW)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );
    assign pc_hold[g]     = bus.pc_hold;
    assign ifid_hold[g]   = bus.ifid_hold;
    assign idex_bubble[g] = bus.idex_bubble;
    assign flush_ifid[g]  = bus.flush_ifid;
    assign flush_idex[g]  = bus.flush_idex;
    assign stall_cnt[g]   = 32'(bus.stall_count);
    assign flush_cnt[g]   = 32'(bus.flush_count);
  end

  // Reference: cycle at which each register becomes usable by an EX consumer / ID branch.
  int unsigned load_lat [NI] = '{1, 3, 1};
  longint      max_cnt  [NI] = '{65535, 65535, 3};
  longint      ready_ex [NI][32];
  longint      ready_br [NI][32];
  longint      m_stall  [NI];
  longint      m_flush  [NI];
  longint      cyc = 0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_busy(input int i, input logic [4:0] r, input logic br);
    return br ? (cyc < ready_br[i][r]) : (cyc < ready_ex[i][r]);
  endfunction

  function automatic logic m_hazard(input int i);
    return id_valid && ((id_use_rs && m_busy(i, id_rs, id_branch)) ||
                        (id_use_rt && m_busy(i, id_rt, id_branch)));
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NI; i++) begin
      for (int r = 0; r < 32; r++) begin
        ready_ex[i][r] = 0;
        ready_br[i][r] = 0;
      end
      m_stall[i] = 0;
      m_flush[i] = 0;
    end
  endtask

  // One cycle: compare at the falling edge, advance the reference at the rising edge.
  task automatic step();
    logic [NI-1:0] haz;
    logic [4:0]    exp_o;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      haz[i] = rst_n && m_hazard(i);
      exp_o  = '0;
      if (rst_n) begin
        exp_o = {haz[i] & ~ex_br_taken, haz[i] & ~ex_br_taken, haz[i] | ex_br_taken,
                 ex_br_taken | (id_valid & id_jump & ~haz[i]), ex_br_taken};
      end
      check($sformatf("ctl%0d", i),
            32'({pc_hold[i], ifid_hold[i], idex_bubble[i], flush_ifid[i], flush_idex[i]}),
            32'(exp_o));
      check($sformatf("stall_count%0d", i), stall_cnt[i], 32'(m_stall[i]));
      check($sformatf("flush_count%0d", i), flush_cnt[i], 32'(m_flush[i]));
    end
    @(posedge clk);
    if (rst_n) begin
      for (int i = 0; i < NI; i++) begin
        if (haz[i] && !ex_br_taken && m_stall[i] < max_cnt[i]) m_stall[i]++;
        if ((ex_br_taken || (id_valid && id_jump && !haz[i])) && m_flush[i] < max_cnt[i])
          m_flush[i]++;
        if (id_valid && !haz[i] && !ex_br_taken && id_regwrite && id_rd != 0) begin
          longint lat = id_memread ? longint'(load_lat[i]) : 0;
          ready_ex[i][id_rd] = cyc + lat + 1;
          ready_br[i][id_rd] = cyc + lat + BR_EXTRA + 1;
        end
      end
    end
    cyc++;
    #1;
  endtask

  function automatic logic any_hazard();
    logic h = 1'b0;
    for (int i = 0; i < NI; i++) h |= m_hazard(i);
    return h;
  endfunction

  task automatic drive(input logic v, input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                       input logic urt, input logic [4:0] rd, input logic rw, input logic mr,
                       input logic br, input logic jp, input logic taken);
    id_valid = v;  id_rs = rs;  id_use_rs = urs;  id_rt = rt;  id_use_rt = urt;  id_rd = rd;
    id_regwrite = rw;  id_memread = mr;  id_branch = br;  id_jump = jp;  ex_br_taken = taken;
  endtask

  // Present an instruction and keep it in ID while any configuration still holds it.
  task automatic instr(input logic v, input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                       input logic urt, input logic [4:0] rd, input logic rw, input logic mr,
                       input logic br, input logic jp, input logic taken);
    logic held;
    drive(v, rs, urs, rt, urt, rd, rw, mr, br, jp, taken);
    for (int k = 0; k < 12; k++) begin
      held = any_hazard();
      step();
      ex_br_taken = 1'b0;
      if (!held || taken) break;
    end
  endtask

  task automatic nop();
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_clear();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    rst_n = 1'b1;
    nop();

    // lw r8; add r9,r8,r2
    instr(1, 0, 1, 0, 0, 8, 1, 1, 0, 0, 0);
    instr(1, 8, 1, 2, 1, 9, 1, 0, 0, 0, 0);
    nop();
    // add r8; beq r8,r3; lw r8; beq r8,r3; add r8; add r9,r8
    instr(1, 1, 1, 2, 1, 8, 1, 0, 0, 0, 0);
    instr(1, 8, 1, 3, 1, 0, 0, 0, 1, 0, 0);
    instr(1, 0, 1, 0, 0, 8, 1, 1, 0, 0, 0);
    instr(1, 8, 1, 3, 1, 0, 0, 0, 1, 0, 0);
    instr(1, 1, 1, 2, 1, 8, 1, 0, 0, 0, 0);
    instr(1, 8, 1, 0, 0, 9, 1, 0, 0, 0, 0);
    nop();
    // lw r8; lw r7,(r8) killed by redirect; add r9,r7 must not wait on the killed load
    instr(1, 0, 1, 0, 0, 8, 1, 1, 0, 0, 0);
    instr(1, 8, 1, 0, 0, 7, 1, 1, 0, 0, 1);
    instr(1, 7, 1, 0, 0, 9, 1, 0, 0, 0, 0);
    nop();
    // lw r5; add r6,r5; lw r0; add r1,r0
    instr(1, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0);
    instr(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
    instr(1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    instr(1, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0);
    nop();
    // lw r8; jr r8
    instr(1, 0, 1, 0, 0, 8, 1, 1, 0, 0, 0);
    instr(1, 8, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    nop();

    // Asynchronous reset in the middle of a load-use stall
    instr(1, 0, 1, 0, 0, 8, 1, 1, 0, 0, 0);
    drive(1, 8, 1, 0, 0, 9, 1, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_ctl%0d", i),
            32'({pc_hold[i], ifid_hold[i], idex_bubble[i], flush_ifid[i], flush_idex[i]}), 0);
      check($sformatf("rst_stall%0d", i), stall_cnt[i], 0);
    end
    m_clear();
    step();
    step();
    rst_n = 1'b1;
    instr(1, 8, 1, 0, 0, 9, 1, 0, 0, 0, 0);
    nop();

    // Random instruction stream over a small register window to provoke frequent hazards
    for (int n = 0; n < 400; n++) begin
      logic       v, mr, br, jp, tk;
      logic [4:0] rs, rt, rd;
      v  = ($urandom_range(0, 9) < 8);
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      mr = ($urandom_range(0, 2) == 0);
      br = ($urandom_range(0, 6) == 0);
      jp = !br && ($urandom_range(0, 15) == 0);
      tk = ($urandom_range(0, 19) == 0);
      instr(v, rs, 1'($urandom_range(0, 1)), rt, 1'($urandom_range(0, 1)), rd,
            !br && !jp, mr, br, jp, tk);
    end

    check("stall_count_saturated", stall_cnt[2], 3);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
